// File: rtl/fifo_req_source.sv
// rtl/fifo_req_source.sv - arbiter-facing input queue with registered request and status
//
// Purpose:
//   Buffers producer words ahead of one port of the two-port round-robin
//   arbiter. The arbiter sees a registered non-empty indication (request) and
//   answers with a combinational pop. The popped word appears on data_out one
//   cycle later, lined up with the arbiter's registered valid/port-select.
//
// Ports:
//   clk          single clock, all state on rising edge
//   reset_L      asynchronous active-low reset
//   push         producer write request
//   data_in      word written on an accepted push
//   pop          read request from the arbiter (combinational on its side)
//   data_out     word read by the last accepted pop, held otherwise
//   request      registered ~empty, feeds arbiter request input
//   empty        occupancy == 0
//   full         occupancy == depth
//   almost_full  occupancy >= ALMOST_FULL
//   almost_empty occupancy <= ALMOST_EMPTY
//   count        current occupancy, 0..depth
//   error        sticky overflow/underflow flag, cleared only by reset

module fifo_req_source #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 2,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  request,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  pop_acc;
    logic                  push_acc;
    logic [CNT_W-1:0]      count_nxt;
    logic                  err_nxt;

    // Acceptance decisions. A pop only needs something stored; there is no
    // bypass of a same-cycle push into an empty queue. A push into a full
    // queue is still accepted when the same edge frees a slot.
    always_comb begin
        pop_acc  = pop && !empty;
        push_acc = push && (!full || pop_acc);

        count_nxt = count;
        if (push_acc && !pop_acc) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            count_nxt = count - CNT_W'(1);
        end

        // Any rejected request is an overflow or underflow.
        err_nxt = (push && !push_acc) || (pop && !pop_acc);
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are registered from the next occupancy so each one matches the
    // registered count, and request never depends combinationally on pop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            error        <= 1'b0;
            request      <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            count        <= count_nxt;
            error        <= error | err_nxt;
            request      <= (count_nxt != '0);
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

endmodule

// File: tb/tb_fifo_req_source.sv
// tb/tb_fifo_req_source.sv - randomized and directed self-checking bench for fifo_req_source

module tb_fifo_req_source;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk;
    logic          reset_L;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          request;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          error;

    fifo_req_source #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ALMOST_FULL  (AF),
        .ALMOST_EMPTY (AE)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .request      (request),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents as an ordered list of words.
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_dout;
    bit            m_err;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    // One rising edge of behaviour, applied to the model.
    task automatic model_edge(input bit p, input logic [DW-1:0] d, input bit o);
        bit pop_ok;
        bit push_ok;
        pop_ok  = o && (m_q.size() > 0);
        push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
        if ((p && !push_ok) || (o && !pop_ok)) m_err = 1'b1;
        if (pop_ok) m_dout = m_q.pop_front();
        if (push_ok) m_q.push_back(d);
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = m_q.size();
        check({tag, ".count"},        32'(count),        n);
        check({tag, ".empty"},        32'(empty),        (n == 0) ? 1 : 0);
        check({tag, ".request"},      32'(request),      (n != 0) ? 1 : 0);
        check({tag, ".full"},         32'(full),         (n == DEPTH) ? 1 : 0);
        check({tag, ".almost_full"},  32'(almost_full),  (n >= AF) ? 1 : 0);
        check({tag, ".almost_empty"}, 32'(almost_empty), (n <= AE) ? 1 : 0);
        check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
        check({tag, ".error"},        32'(error),        32'(m_err));
    endtask

    // Called at posedge+1: drive inputs, take the edge, check at posedge+1.
    task automatic step(input string tag, input bit p, input logic [DW-1:0] d, input bit o);
        push    = p;
        data_in = d;
        pop     = o;
        @(posedge clk);
        model_edge(p, d, o);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        compare_all(tag);
    endtask

    // Reset dropped between edges while a transfer is being presented.
    task automatic async_reset(input string tag);
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'($urandom);
        #3;
        reset_L = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".mid"});
        @(posedge clk);
        #1;
        compare_all({tag, ".held"});
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] seq [4];
        logic [DW-1:0] dv;
        seq[0] = 6'h11; seq[1] = 6'h22; seq[2] = 6'h33; seq[3] = 6'h04;

        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset_L = 1'b1;
        step("idle", 1'b0, 6'h00, 1'b0);

        // Fill to full.
        for (int i = 0; i < 4; i++) step("fill", 1'b1, seq[i], 1'b0);

        // Overflow is dropped and flagged.
        step("ovf", 1'b1, 6'h3F, 1'b0);

        // Drain in order, then one cycle of idle to see data_out hold.
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 6'h00, 1'b1);
        step("hold", 1'b0, 6'h00, 1'b0);

        // Clean error, then steady-state push+pop at occupancy 2 with wrap.
        async_reset("rst1");
        step("pre0", 1'b1, 6'h01, 1'b0);
        step("pre1", 1'b1, 6'h02, 1'b0);
        for (int i = 0; i < 10; i++) step("pp2", 1'b1, 6'(8'h10 + i), 1'b1);

        // Drain back to empty, then push+pop when empty.
        step("dr0", 1'b0, 6'h00, 1'b1);
        step("dr1", 1'b0, 6'h00, 1'b1);
        step("pp_empty", 1'b1, 6'h05, 1'b1);
        step("pop_after", 1'b0, 6'h00, 1'b1);

        // Full with simultaneous push+pop after a reset.
        async_reset("rst2");
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, seq[i], 1'b0);
        step("pp_full", 1'b1, 6'h2A, 1'b1);

        // Reset mid-burst, then make sure fresh data comes out.
        step("burst", 1'b1, 6'h15, 1'b1);
        async_reset("rst3");
        step("fresh_push", 1'b1, 6'h2B, 1'b0);
        step("fresh_pop", 1'b0, 6'h00, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_reset("rrst");
            end else begin
                dv = 6'($urandom);
                step("rand", ($urandom_range(0, 99) < 55), dv, ($urandom_range(0, 99) < 45));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_req_source.md
Name: fifo_req_source

Overview:
- Input queue directly upstream of the two-port round-robin arbiter; one instance per arbitrated port.
- Buffers data words from the producer.
- Presents a registered non-empty `request` to the arbiter and accepts the arbiter's combinational pop.
- Drives the popped word one cycle later, aligned with the arbiter's registered valid/port-select outputs, for the downstream mux.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 2, pointer width; depth = 2**ADDR_WIDTH (default 4).
- ALMOST_FULL, 3, occupancy at or above which `almost_full` asserts.
- ALMOST_EMPTY, 1, occupancy at or below which `almost_empty` asserts.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  write request from producer.
- data_in  input  DATA_WIDTH  word written on accepted push.
- pop  input  1  read request; driven combinationally by the arbiter (pop_0/pop_1).
- data_out  output  DATA_WIDTH  registered word from the last accepted pop.
- request  output  1  registered, equals ~empty; feeds arbiter request0/request1.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == depth.
- almost_full  output  1  occupancy >= ALMOST_FULL.
- almost_empty  output  1  occupancy <= ALMOST_EMPTY.
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
- error  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset_L low, asynchronous, at any time including mid-transfer):
  - Pointers and count go to 0; data_out = 0; error = 0.
  - empty = 1, request = 0, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are don't-care.
- Storage: circular buffer with wr_ptr and rd_ptr of ADDR_WIDTH bits. Pointers wrap modulo depth with no special case. Occupancy is held in count; full and empty are derived from count, not from pointer equality.
- Accepted push: push && (!full || pop_accepted). On accept, mem[wr_ptr] <= data_in and wr_ptr increments.
- Accepted pop: pop && !empty. On accept, data_out <= mem[rd_ptr] at the same edge and rd_ptr increments. Read latency is 1 cycle from pop to data_out.
- data_out holds its value when no pop is accepted.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - When full: both accepted, count stays at depth, no error.
  - When empty: push accepted; pop rejected (nothing to read, no bypass); error set; count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Push while full without pop: word dropped, state unchanged, error <= 1.
- Pop while empty: ignored, data_out unchanged, error <= 1.
- error is sticky until reset.
- Status flags are registered/derived from the registered count and valid in the cycle after the causing edge. There is no combinational path from pop or push to request, which avoids a loop with the arbiter's combinational pop.
- Illegal parameter combinations (ALMOST_FULL > depth, ALMOST_EMPTY >= ALMOST_FULL) are outside spec.

Test Plan:
- Reset then idle -> count=0, empty=1, request=0, almost_empty=1, data_out=0, error=0.
- Push 0x11,0x22,0x33,0x04 on consecutive cycles -> after 4th edge count=4, full=1, almost_full=1 from count=3, request=1 from first edge+0 cycle after push.
- Full, push 0x3F without pop -> dropped, count=4, error=1; then pop x4 -> data_out 0x11,0x22,0x33,0x04 one cycle after each pop, empty=1 after last.
- Depth-2 occupancy, push+pop same cycle for 10 cycles with incrementing data -> count stays 2, pointers wrap, output order matches input order, error=0.
- Empty, push 0x05 and pop same cycle -> count=1, data_out unchanged, error=1; next cycle pop -> data_out=0x05, count=0.
- Assert reset_L low mid-burst between clock edges -> outputs clear immediately (before next clk edge); after release, first push/pop pair returns new data, not stale.
